// File: rtl/pfd_sampler_if.sv
// Signal bundle between the PLL controller side and the pfd_sampler detector.
// master drives the async clocks and enable; slave is the detector itself.
interface pfd_sampler_if #(
    parameter int CNT_W = 8
) ();
    logic             enable;
    logic             ref_in;
    logic             fb_in;
    logic             p_up;
    logic             p_down;
    logic             phase_clk;
    logic [CNT_W:0]   phase_err;
    logic             err_valid;
    logic             slip;
    logic [2:0]       state_dbg;

    // No ready/valid backpressure here: err_valid is a one-cycle strobe that
    // qualifies phase_err; the consumer must sample it on that cycle.
    modport master (
        output enable, ref_in, fb_in,
        input  p_up, p_down, phase_clk, phase_err, err_valid, slip, state_dbg
    );

    modport slave (
        input  enable, ref_in, fb_in,
        output p_up, p_down, phase_clk, phase_err, err_valid, slip, state_dbg
    );
endinterface

// File: rtl/pfd_sampler.sv
// Clocked phase-frequency detector: synchronizes ref/fb, detects rising edges,
// drives active-low up/down pulses, a signed phase error and a sticky slip flag.
module pfd_sampler #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int MIN_PULSE   = 1,
    parameter int MAX_PULSE   = 200
) (
    input  logic          clk,
    input  logic          reset,
    pfd_sampler_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_UP      = 3'd1,
        S_DN      = 3'd2,
        S_RELEASE = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    state_t                   r_state, w_state_nx;
    logic [SYNC_STAGES-1:0]   r_ref_sync, r_fb_sync;
    logic                     r_ref_d1, r_ref_d2, r_fb_d1, r_fb_d2;
    logic                     r_ref_e, r_fb_e;
    logic                     r_ref_p, r_fb_p, w_ref_p_nx, w_fb_p_nx;
    logic                     r_opp_lat, w_opp_lat_nx;
    logic                     r_hold_up, w_hold_up_nx;
    logic [CNT_W-1:0]         r_cnt, w_cnt_nx;
    logic [CNT_W:0]           r_err, w_err_nx;
    logic                     r_err_valid, w_err_valid_nx;
    logic                     r_slip, w_slip_nx;
    logic                     r_p_up, r_p_down, r_phase_clk;
    logic                     w_ref_any, w_fb_any, w_opp, w_same;

    // Front end: synchronizer chain, then a two-flop registered edge detector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ref_sync <= '0;
            r_fb_sync  <= '0;
            r_ref_d1   <= 1'b0;
            r_ref_d2   <= 1'b0;
            r_fb_d1    <= 1'b0;
            r_fb_d2    <= 1'b0;
            r_ref_e    <= 1'b0;
            r_fb_e     <= 1'b0;
        end else if (!bus.enable) begin
            r_ref_sync <= '0;
            r_fb_sync  <= '0;
            r_ref_d1   <= 1'b0;
            r_ref_d2   <= 1'b0;
            r_fb_d1    <= 1'b0;
            r_fb_d2    <= 1'b0;
            r_ref_e    <= 1'b0;
            r_fb_e     <= 1'b0;
        end else begin
            r_ref_sync <= {r_ref_sync[SYNC_STAGES-2:0], bus.ref_in};
            r_fb_sync  <= {r_fb_sync[SYNC_STAGES-2:0], bus.fb_in};
            r_ref_d1   <= r_ref_sync[SYNC_STAGES-1];
            r_ref_d2   <= r_ref_d1;
            r_fb_d1    <= r_fb_sync[SYNC_STAGES-1];
            r_fb_d2    <= r_fb_d1;
            r_ref_e    <= r_ref_d1 & ~r_ref_d2;
            r_fb_e     <= r_fb_d1 & ~r_fb_d2;
        end
    end

    assign w_ref_any = r_ref_e | r_ref_p;
    assign w_fb_any  = r_fb_e | r_fb_p;
    // In HOLDOFF the side that timed out is "same"; the other side releases it.
    assign w_opp     = r_hold_up ? r_fb_e : r_ref_e;
    assign w_same    = r_hold_up ? r_ref_e : r_fb_e;

    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_err_nx       = r_err;
        w_err_valid_nx = 1'b0;
        w_slip_nx      = r_slip;
        w_ref_p_nx     = r_ref_p;
        w_fb_p_nx      = r_fb_p;
        w_opp_lat_nx   = r_opp_lat;
        w_hold_up_nx   = r_hold_up;
        case (r_state)
            S_IDLE: begin
                w_ref_p_nx   = 1'b0;
                w_fb_p_nx    = 1'b0;
                w_opp_lat_nx = 1'b0;
                if (w_ref_any && w_fb_any) begin
                    w_state_nx     = S_RELEASE;
                    w_err_nx       = '0;
                    w_err_valid_nx = 1'b1;
                end else if (w_ref_any) begin
                    w_state_nx = S_UP;
                    w_cnt_nx   = CNT_W'(1);
                end else if (w_fb_any) begin
                    w_state_nx = S_DN;
                    w_cnt_nx   = CNT_W'(1);
                end
            end
            S_UP, S_DN: begin
                w_cnt_nx = r_cnt + CNT_W'(1);
                if (((r_state == S_UP) ? r_fb_e : r_ref_e) || r_opp_lat) begin
                    if (r_cnt >= CNT_W'(MIN_PULSE)) begin
                        w_state_nx     = S_RELEASE;
                        w_err_nx       = (r_state == S_UP) ? {1'b0, r_cnt} : -{1'b0, r_cnt};
                        w_err_valid_nx = 1'b1;
                    end else begin
                        w_opp_lat_nx = 1'b1;
                    end
                end else if (r_cnt == CNT_W'(MAX_PULSE)) begin
                    w_state_nx     = S_HOLDOFF;
                    w_err_nx       = (r_state == S_UP) ? {1'b0, r_cnt} : -{1'b0, r_cnt};
                    w_err_valid_nx = 1'b1;
                    w_slip_nx      = 1'b1;
                    w_hold_up_nx   = (r_state == S_UP);
                end
            end
            S_HOLDOFF: begin
                if (w_opp) w_state_nx = S_RELEASE;
                if (w_same) begin
                    if (r_hold_up) w_ref_p_nx = 1'b1;
                    else           w_fb_p_nx  = 1'b1;
                end
            end
            S_RELEASE: begin
                w_state_nx = S_IDLE;
                w_ref_p_nx = r_ref_p | r_ref_e;
                w_fb_p_nx  = r_fb_p | r_fb_e;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_err       <= '0;
            r_err_valid <= 1'b0;
            r_slip      <= 1'b0;
            r_ref_p     <= 1'b0;
            r_fb_p      <= 1'b0;
            r_opp_lat   <= 1'b0;
            r_hold_up   <= 1'b0;
            r_p_up      <= 1'b1;
            r_p_down    <= 1'b1;
            r_phase_clk <= 1'b1;
        end else if (!bus.enable) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_err       <= '0;
            r_err_valid <= 1'b0;
            r_ref_p     <= 1'b0;
            r_fb_p      <= 1'b0;
            r_opp_lat   <= 1'b0;
            r_hold_up   <= 1'b0;
            r_p_up      <= 1'b1;
            r_p_down    <= 1'b1;
            r_phase_clk <= 1'b1;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_err       <= w_err_nx;
            r_err_valid <= w_err_valid_nx;
            r_slip      <= w_slip_nx;
            r_ref_p     <= w_ref_p_nx;
            r_fb_p      <= w_fb_p_nx;
            r_opp_lat   <= w_opp_lat_nx;
            r_hold_up   <= w_hold_up_nx;
            r_p_up      <= (w_state_nx != S_UP);
            r_p_down    <= (w_state_nx != S_DN);
            r_phase_clk <= (w_state_nx == S_IDLE);
        end
    end

    assign bus.p_up      = r_p_up;
    assign bus.p_down    = r_p_down;
    assign bus.phase_clk = r_phase_clk;
    assign bus.phase_err = r_err;
    assign bus.err_valid = r_err_valid;
    assign bus.slip      = r_slip;
    assign bus.state_dbg = r_state;
endmodule

// File: tb/tb_pfd_sampler.sv
// Directed bench for pfd_sampler: lead/lag/simultaneous edges, timeout slip,
// enable hold of slip and asynchronous reset mid-pulse.
module tb_pfd_sampler;
    localparam int CNT_W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    pfd_sampler_if #(.CNT_W(CNT_W)) bus ();

    pfd_sampler #(
        .SYNC_STAGES(2),
        .CNT_W      (CNT_W),
        .MIN_PULSE  (1),
        .MAX_PULSE  (20)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int             up_low, dn_low, pclk_low, ev_cnt;
    logic [CNT_W:0] last_err;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor samples 1 ns after each active edge.
    always @(posedge clk) begin
        #1;
        if (bus.p_up === 1'b0)      up_low++;
        if (bus.p_down === 1'b0)    dn_low++;
        if (bus.phase_clk === 1'b0) pclk_low++;
        if (bus.err_valid === 1'b1) begin
            ev_cnt++;
            last_err = bus.phase_err;
        end
    end

    task automatic clear_mon();
        up_low   = 0;
        dn_low   = 0;
        pclk_low = 0;
        ev_cnt   = 0;
        last_err = '0;
    endtask

    // Each input is driven high for 3 cycles starting at its offset; -1 = no edge.
    task automatic run_pair(input int d_ref, input int d_fb);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.ref_in = (d_ref >= 0) && (c >= d_ref) && (c < d_ref + 3);
            bus.fb_in  = (d_fb >= 0) && (c >= d_fb) && (c < d_fb + 3);
        end
        @(negedge clk);
        bus.ref_in = 1'b0;
        bus.fb_in  = 1'b0;
    endtask

    initial begin
        bus.enable = 1'b1;
        bus.ref_in = 1'b0;
        bus.fb_in  = 1'b0;
        clear_mon();
        #2 reset = 1'b0;

        // Reset held with toggling inputs.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq("rst_p_up",      32'(bus.p_up),      32'h1);
            check_eq("rst_p_down",    32'(bus.p_down),    32'h1);
            check_eq("rst_phase_clk", 32'(bus.phase_clk), 32'h1);
            check_eq("rst_phase_err", 32'(bus.phase_err), 32'h0);
            check_eq("rst_slip",      32'(bus.slip),      32'h0);
            bus.ref_in = (c % 2) == 0;
            bus.fb_in  = (c % 3) == 0;
        end
        @(negedge clk);
        bus.ref_in = 1'b0;
        bus.fb_in  = 1'b0;
        reset = 1'b1;
        repeat (6) @(negedge clk);

        // Ref leads by 5.
        clear_mon();
        run_pair(0, 5);
        check_eq("lead5_up_low", 32'(up_low),   32'd5);
        check_eq("lead5_dn_low", 32'(dn_low),   32'd0);
        check_eq("lead5_err",    32'(last_err), 32'h005);
        check_eq("lead5_ev",     32'(ev_cnt),   32'd1);
        check_eq("lead5_pclk",   32'(pclk_low), 32'd6);

        // Fb leads by 3.
        clear_mon();
        run_pair(3, 0);
        check_eq("lag3_dn_low", 32'(dn_low),   32'd3);
        check_eq("lag3_up_low", 32'(up_low),   32'd0);
        check_eq("lag3_err",    32'(last_err), 32'h1FD);
        check_eq("lag3_ev",     32'(ev_cnt),   32'd1);
        check_eq("lag3_pclk",   32'(pclk_low), 32'd4);

        // Simultaneous edges.
        clear_mon();
        last_err = 9'h0AA;
        run_pair(0, 0);
        check_eq("sim_err",    32'(last_err), 32'h000);
        check_eq("sim_ev",     32'(ev_cnt),   32'd1);
        check_eq("sim_pclk",   32'(pclk_low), 32'd1);
        check_eq("sim_up_low", 32'(up_low),   32'd0);
        check_eq("sim_dn_low", 32'(dn_low),   32'd0);

        // Ref with no fb: timeout into HOLDOFF.
        clear_mon();
        run_pair(0, -1);
        check_eq("to_up_low", 32'(up_low),        32'd20);
        check_eq("to_err",    32'(last_err),      32'h014);
        check_eq("to_ev",     32'(ev_cnt),        32'd1);
        check_eq("to_slip",   32'(bus.slip),      32'h1);
        check_eq("to_p_up",   32'(bus.p_up),      32'h1);
        check_eq("to_pclk",   32'(bus.phase_clk), 32'h0);
        check_eq("to_state",  32'(bus.state_dbg), 32'd4);

        // Next fb edge is consumed without a comparison.
        clear_mon();
        run_pair(-1, 0);
        check_eq("hold_ev",     32'(ev_cnt),        32'd0);
        check_eq("hold_dn_low", 32'(dn_low),        32'd0);
        check_eq("hold_pclk",   32'(bus.phase_clk), 32'h1);
        check_eq("hold_state",  32'(bus.state_dbg), 32'd0);
        check_eq("hold_slip",   32'(bus.slip),      32'h1);

        // Enable low keeps slip but forces the rest idle.
        @(negedge clk);
        bus.enable = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("en_slip", 32'(bus.slip),      32'h1);
        check_eq("en_pclk", 32'(bus.phase_clk), 32'h1);
        check_eq("en_err",  32'(bus.phase_err), 32'h0);
        bus.enable = 1'b1;
        repeat (3) @(negedge clk);

        // Reset mid-UP; also checks edge-to-p_up latency.
        clear_mon();
        bus.ref_in = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) bus.ref_in = 1'b0;
            if (k == 4) check_eq("lat_p_up_hi", 32'(bus.p_up), 32'h1);
            if (k == 5) check_eq("lat_p_up_lo", 32'(bus.p_up), 32'h0);
        end
        #2 reset = 1'b0;
        #1;
        check_eq("arst_p_up",  32'(bus.p_up),      32'h1);
        check_eq("arst_pclk",  32'(bus.phase_clk), 32'h1);
        check_eq("arst_slip",  32'(bus.slip),      32'h0);
        check_eq("arst_err",   32'(bus.phase_err), 32'h0);
        check_eq("arst_ev",    32'(bus.err_valid), 32'h0);
        run_pair(-1, 0);
        check_eq("arst_no_ev", 32'(ev_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);

        // Normal operation after reset release.
        clear_mon();
        run_pair(0, 2);
        check_eq("post_up_low", 32'(up_low),   32'd2);
        check_eq("post_err",    32'(last_err), 32'h002);
        check_eq("post_ev",     32'(ev_cnt),   32'd1);
        check_eq("post_slip",   32'(bus.slip), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
